// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: result/size encodings, done opcode, halt states
// and the decode-control bundle with its bubble value.
package riscv_pipe_pkg;

  localparam int         DRAIN_CYCLES_DEF = 3;
  localparam logic [6:0] DONE_OPCODE      = 7'b0000000;
  localparam int         ALUCTRL_W        = 4;

  typedef enum logic [2:0] {
    RES_ALU   = 3'b000,
    RES_LOAD  = 3'b001,
    RES_PC4   = 3'b010,
    RES_IMM   = 3'b011,
    RES_PCIMM = 3'b100
  } result_src_e;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_e;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 alu_src;
    logic                 jump;
    logic                 done;
    logic                 beq;
    logic                 bne;
    logic                 blt;
    logic                 bge;
    logic                 bltu;
    logic                 bgeu;
    logic [2:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [2:0]           size;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
  } ctrl_t;

  // A bubble is all-zero: no writes, no branch, ResultSrc=ALU, x0 indices.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_halt_drain_fsm.sv
// Halt sequencer: after `done` is captured, force DRAIN_CYCLES bubbles through
// EX, then hold forever with haltedE set one edge after entering HALTED.
module halt_drain_fsm
  import riscv_pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic doneD,
  input  logic StallE,
  input  logic FlushE,
  output logic load_bubble,
  output logic hold,
  output logic haltedE
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  halt_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      halted_q <= halted_q | (state == ST_HALTED);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (doneD && !FlushE && !StallE) begin
          state_n = ST_DRAIN;
          cnt_n   = CW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        // A flush still loads a bubble into EX, so it advances the drain too.
        if (FlushE || !StallE) begin
          cnt_n = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = ST_HALTED;
        end
      end
      ST_HALTED: ;
      default: state_n = ST_RUN;
    endcase
  end

  assign load_bubble = (state == ST_DRAIN);
  assign hold        = (state == ST_HALTED);
  assign haltedE     = halted_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush and post-`done` drain/halt.
// Optional IDEX_PERF_CNT_EN adds a 32-bit flush-bubble counter port.
module id_ex_pipe_reg
  import riscv_pipe_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int XLEN         = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 RegWriteD,
  input  logic                 Mem_WriteD,
  input  logic                 ALUSrcD,
  input  logic                 JumpD,
  input  logic                 doneD,
  input  logic                 beqD,
  input  logic                 bneD,
  input  logic                 bltD,
  input  logic                 bgeD,
  input  logic                 bltuD,
  input  logic                 bgeuD,
  input  logic [2:0]           ResultSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [2:0]           sizeD,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           RdD,
  output logic                 RegWriteE,
  output logic                 Mem_WriteE,
  output logic                 ALUSrcE,
  output logic                 JumpE,
  output logic                 doneE,
  output logic                 beqE,
  output logic                 bneE,
  output logic                 bltE,
  output logic                 bgeE,
  output logic                 bltuE,
  output logic                 bgeuE,
  output logic [2:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [2:0]           sizeE,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [4:0]           Rs1E,
  output logic [4:0]           Rs2E,
  output logic [4:0]           RdE,
  output logic                 BranchE,
  output logic                 haltedE
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]          bubble_cnt
`endif
);

  ctrl_t ctrl_d, ctrl_q;
  logic  load_bubble, hold, bubble_now;

  halt_drain_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .doneD       (doneD),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .load_bubble (load_bubble),
    .hold        (hold),
    .haltedE     (haltedE)
  );

  always_comb begin
    ctrl_d             = CTRL_BUBBLE;
    // The done instruction itself must never write the register file.
    ctrl_d.reg_write   = RegWriteD & ~doneD;
    ctrl_d.mem_write   = Mem_WriteD;
    ctrl_d.alu_src     = ALUSrcD;
    ctrl_d.jump        = JumpD;
    ctrl_d.done        = doneD;
    ctrl_d.beq         = beqD;
    ctrl_d.bne         = bneD;
    ctrl_d.blt         = bltD;
    ctrl_d.bge         = bgeD;
    ctrl_d.bltu        = bltuD;
    ctrl_d.bgeu        = bgeuD;
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.size        = sizeD;
    ctrl_d.rs1         = Rs1D;
    ctrl_d.rs2         = Rs2D;
    ctrl_d.rd          = RdD;
  end

  // Flush beats stall; a drain bubble only loads on a non-stalled edge.
  assign bubble_now = FlushE | (load_bubble & ~StallE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_BUBBLE;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
    end else if (!hold) begin
      if (bubble_now) begin
        ctrl_q   <= CTRL_BUBBLE;
        RD1E     <= '0;
        RD2E     <= '0;
        ImmExtE  <= '0;
        PCE      <= '0;
        PCPlus4E <= '0;
      end else if (!StallE) begin
        ctrl_q   <= ctrl_d;
        RD1E     <= RD1D;
        RD2E     <= RD2D;
        ImmExtE  <= ImmExtD;
        PCE      <= PCD;
        PCPlus4E <= PCPlus4D;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                bubble_cnt <= '0;
    else if (FlushE && !hold) bubble_cnt <= bubble_cnt + 32'd1;
  end
`endif

  assign RegWriteE   = ctrl_q.reg_write;
  assign Mem_WriteE  = ctrl_q.mem_write;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign JumpE       = ctrl_q.jump;
  assign doneE       = ctrl_q.done;
  assign beqE        = ctrl_q.beq;
  assign bneE        = ctrl_q.bne;
  assign bltE        = ctrl_q.blt;
  assign bgeE        = ctrl_q.bge;
  assign bltuE       = ctrl_q.bltu;
  assign bgeuE       = ctrl_q.bgeu;
  assign ResultSrcE  = ctrl_q.result_src;
  assign ALUControlE = ctrl_q.alu_control;
  assign sizeE       = ctrl_q.size;
  assign Rs1E        = ctrl_q.rs1;
  assign Rs2E        = ctrl_q.rs2;
  assign RdE         = ctrl_q.rd;
  assign BranchE     = ctrl_q.beq | ctrl_q.bne | ctrl_q.blt |
                       ctrl_q.bge | ctrl_q.bltu | ctrl_q.bgeu;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: load, stall, flush, drain/halt, async reset.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0, reset;
  logic        StallE, FlushE;
  logic        RegWriteD, Mem_WriteD, ALUSrcD, JumpD, doneD;
  logic        beqD, bneD, bltD, bgeD, bltuD, bgeuD;
  logic [2:0]  ResultSrcD, sizeD;
  logic [3:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, Mem_WriteE, ALUSrcE, JumpE, doneE;
  logic        beqE, bneE, bltE, bgeE, bltuE, bgeuE;
  logic [2:0]  ResultSrcE, sizeE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        BranchE, haltedE;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DRAIN_CYCLES(3), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .Mem_WriteD(Mem_WriteD), .ALUSrcD(ALUSrcD), .JumpD(JumpD), .doneD(doneD),
    .beqD(beqD), .bneD(bneD), .bltD(bltD), .bgeD(bgeD), .bltuD(bltuD), .bgeuD(bgeuD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .sizeD(sizeD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteE(RegWriteE), .Mem_WriteE(Mem_WriteE), .ALUSrcE(ALUSrcE), .JumpE(JumpE), .doneE(doneE),
    .beqE(beqE), .bneE(bneE), .bltE(bltE), .bgeE(bgeE), .bltuE(bltuE), .bgeuE(bgeuE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .sizeE(sizeE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BranchE(BranchE), .haltedE(haltedE)
`ifdef IDEX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    StallE = 0; FlushE = 0;
    RegWriteD = 0; Mem_WriteD = 0; ALUSrcD = 0; JumpD = 0; doneD = 0;
    beqD = 0; bneD = 0; bltD = 0; bgeD = 0; bltuD = 0; bgeuD = 0;
    ResultSrcD = 0; ALUControlD = 0; sizeD = 0;
    RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0;
  endtask

  task automatic load_add(input logic [4:0] rd);
    clear_d();
    RegWriteD = 1; ALUControlD = 4'b0000; Rs1D = 5'd5; Rs2D = 5'd6; RdD = rd;
    RD1D = 32'd5; RD2D = 32'd9; PCD = 32'h40; PCPlus4D = 32'h44;
  endtask

  task automatic test_reset();
    clear_d();
    RegWriteD = 1; RdD = 5'd3; RD1D = 32'hFFFF_FFFF;
    reset = 1;
    step(); step();
    checks++; if (RegWriteE !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b exp 0", RegWriteE); end
    checks++; if (RdE !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d exp 0", RdE); end
    checks++; if (RD1E !== 32'd0) begin errors++; $display("FAIL reset_rd1: got %h exp 0", RD1E); end
    checks++; if (haltedE !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b exp 0", haltedE); end
`ifdef IDEX_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd0) begin errors++; $display("FAIL reset_bubble_cnt: got %0d exp 0", bubble_cnt); end
`endif
    reset = 0;
  endtask

  task automatic test_add();
    load_add(5'd7);
    step();
    checks++; if (RegWriteE !== 1'b1) begin errors++; $display("FAIL add_regwrite: got %b exp 1", RegWriteE); end
    checks++; if (RdE !== 5'd7) begin errors++; $display("FAIL add_rd: got %0d exp 7", RdE); end
    checks++; if (RD1E !== 32'd5 || RD2E !== 32'd9) begin errors++; $display("FAIL add_ops: got %0d,%0d exp 5,9", RD1E, RD2E); end
    checks++; if (BranchE !== 1'b0) begin errors++; $display("FAIL add_branch: got %b exp 0", BranchE); end
    // AUIPC-style bundle exercises the wide control fields
    clear_d();
    RegWriteD = 1; ALUSrcD = 1; ResultSrcD = 3'b100; ALUControlD = 4'b1010; sizeD = 3'b101;
    ImmExtD = 32'hABCD_E000; PCD = 32'h80; PCPlus4D = 32'h84; RdD = 5'd31;
    step();
    checks++; if ({ResultSrcE, ALUControlE, sizeE} !== {3'b100, 4'b1010, 3'b101}) begin errors++; $display("FAIL auipc_ctrl: got %b exp 1001010101", {ResultSrcE, ALUControlE, sizeE}); end
    checks++; if (ImmExtE !== 32'hABCD_E000 || PCPlus4E !== 32'h84 || ALUSrcE !== 1'b1) begin errors++; $display("FAIL auipc_data: got imm %h pc4 %h src %b", ImmExtE, PCPlus4E, ALUSrcE); end
    clear_d(); bgeuD = 1;
    step();
    checks++; if (BranchE !== 1'b1 || bgeuE !== 1'b1) begin errors++; $display("FAIL bgeu_branch: got %b/%b exp 1/1", BranchE, bgeuE); end
  endtask

  task automatic test_stall();
    clear_d();
    beqD = 1; Rs1D = 5'd1; Rs2D = 5'd2; PCD = 32'h100; PCPlus4D = 32'h104; ImmExtD = 32'h10;
    step();
    checks++; if (beqE !== 1'b1 || BranchE !== 1'b1 || PCE !== 32'h100) begin errors++; $display("FAIL beq_load: got beq %b br %b pc %h exp 1 1 100", beqE, BranchE, PCE); end
    clear_d();
    StallE = 1; RegWriteD = 1; bneD = 1; PCD = 32'h200; RdD = 5'd4;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (PCE !== 32'h100 || beqE !== 1'b1 || BranchE !== 1'b1 || bneE !== 1'b0 || RegWriteE !== 1'b0)
        begin errors++; $display("FAIL stall_hold%0d: got pc %h beq %b br %b bne %b rw %b", i, PCE, beqE, BranchE, bneE, RegWriteE); end
    end
    StallE = 0;
    step();
    checks++; if (PCE !== 32'h200 || bneE !== 1'b1 || beqE !== 1'b0 || RdE !== 5'd4) begin errors++; $display("FAIL stall_release: got pc %h bne %b beq %b rd %0d", PCE, bneE, beqE, RdE); end
  endtask

  task automatic test_flush();
    load_add(5'd7);
    step();
    clear_d();
    FlushE = 1; StallE = 1;
    Mem_WriteD = 1; ALUSrcD = 1; sizeD = 3'b010; Rs1D = 5'd2; Rs2D = 5'd8; RdD = 5'd9;
    RD1D = 32'h1000; RD2D = 32'hDEAD; ImmExtD = 32'h4;
    step();
    checks++; if (Mem_WriteE !== 1'b0 || RegWriteE !== 1'b0 || ALUSrcE !== 1'b0) begin errors++; $display("FAIL flush_ctrl: got mw %b rw %b src %b exp 0", Mem_WriteE, RegWriteE, ALUSrcE); end
    checks++; if (RdE !== 5'd0 || Rs1E !== 5'd0 || Rs2E !== 5'd0 || sizeE !== 3'd0) begin errors++; $display("FAIL flush_idx: got rd %0d rs1 %0d rs2 %0d size %0d exp 0", RdE, Rs1E, Rs2E, sizeE); end
    checks++; if (RD1E !== 32'd0 || RD2E !== 32'd0 || PCE !== 32'd0) begin errors++; $display("FAIL flush_data: got %h %h %h exp 0", RD1E, RD2E, PCE); end
`ifdef IDEX_PERF_CNT_EN
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("FAIL flush_bubble_cnt: got %0d exp 1", bubble_cnt); end
`endif
  endtask

  // Captures done at edge N, then checks bubbles and haltedE timing; stall_at
  // selects the post-N edge index (1-based) that is stalled, 0 for none.
  task automatic test_done(input int stall_at, input string tag);
    int halt_edge;
    halt_edge = (stall_at != 0) ? 5 : 4;
    clear_d();
    doneD = 1; RegWriteD = 1; RdD = 5'd3; PCD = 32'h300;
    step();
    checks++; if (doneE !== 1'b1 || RegWriteE !== 1'b0 || RdE !== 5'd3 || haltedE !== 1'b0)
      begin errors++; $display("FAIL %s_capture: got done %b rw %b rd %0d halt %b exp 1 0 3 0", tag, doneE, RegWriteE, RdE, haltedE); end
    load_add(5'd7);
    for (int e = 1; e <= halt_edge + 20; e++) begin
      StallE = (e == stall_at);
      step();
      if (e < halt_edge) begin
        checks++; if (haltedE !== 1'b0) begin errors++; $display("FAIL %s_early_halt_e%0d: got %b exp 0", tag, e, haltedE); end
      end else begin
        checks++; if (haltedE !== 1'b1) begin errors++; $display("FAIL %s_halted_e%0d: got %b exp 1", tag, e, haltedE); end
      end
      if (e != stall_at && !(e == 1 && stall_at == 1)) begin
        checks++; if (RegWriteE !== 1'b0 || RdE !== 5'd0 || RD1E !== 32'd0)
          begin errors++; $display("FAIL %s_bubble_e%0d: got rw %b rd %0d rd1 %h exp 0", tag, e, RegWriteE, RdE, RD1E); end
      end
      FlushE = (e == halt_edge + 5);
    end
    clear_d();
  endtask

  task automatic test_reset_mid_drain();
    reset = 1; step(); reset = 0;
    clear_d();
    doneD = 1; RdD = 5'd3; RD1D = 32'h55;
    step();
    load_add(5'd7);
    #2 reset = 1;
    #1;
    checks++; if (doneE !== 1'b0 || RdE !== 5'd0 || RD1E !== 32'd0 || haltedE !== 1'b0)
      begin errors++; $display("FAIL async_reset: got done %b rd %0d rd1 %h halt %b exp 0", doneE, RdE, RD1E, haltedE); end
    #1 reset = 0;
    step();
    checks++; if (RegWriteE !== 1'b1 || RdE !== 5'd7 || RD2E !== 32'd9)
      begin errors++; $display("FAIL post_reset_add: got rw %b rd %0d rd2 %0d exp 1 7 9", RegWriteE, RdE, RD2E); end
    step();
    checks++; if (haltedE !== 1'b0 || RdE !== 5'd7) begin errors++; $display("FAIL post_reset_run: got halt %b rd %0d exp 0 7", haltedE, RdE); end
  endtask

  initial begin
    reset = 1;
    clear_d();
    test_reset();
    test_add();
    test_stall();
    test_flush();
    test_done(0, "done");
    reset = 1; step(); reset = 0;
    test_done(2, "done_stall");
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register of the five-stage RISC-V core: latches every decode-stage control signal from the pipeline control unit plus register operands, immediate, PC and register indices into the execute stage. Supports stall (hold), flush (bubble insertion) and a halt sequencer that drains the pipeline after the `done` opcode (7'b0000000) is decoded. Sits between the decode stage and the ALU/branch logic of EX; stall/flush come from the hazard unit.

## Interface
- `DRAIN_CYCLES`, 3: cycles after `done` enters EX before `haltedE` asserts (EX, MEM, WB retire).
- `XLEN`, 32: datapath width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `StallE` in 1: hold all EX-stage contents.
- `FlushE` in 1: load a bubble.
- `RegWriteD, Mem_WriteD, ALUSrcD, JumpD, doneD` in 1 each: decode controls.
- `beqD, bneD, bltD, bgeD, bltuD, bgeuD` in 1 each: one-hot branch type.
- `ResultSrcD` in 3: 000 ALU, 001 load, 010 PC+4, 011 imm (LUI), 100 PC+imm (AUIPC).
- `ALUControlD` in 4; `sizeD` in 3.
- `RD1D, RD2D, ImmExtD, PCD, PCPlus4D` in XLEN each.
- `Rs1D, Rs2D, RdD` in 5 each.
- Matching `...E` outputs, same widths, for every `...D` input above.
- `BranchE` out 1: OR of the six branch-type outputs.
- `haltedE` out 1: core halted; sticky until reset.
- `bubble_cnt` out 32: present only with `IDEX_PERF_CNT_EN`.

## Operation
- Load priority per rising edge: `reset` > halted > `FlushE` > `StallE` > normal load.
- Normal load: all `E` outputs take `D` inputs.
- Stall: all `E` outputs hold; halt FSM holds state and counter.
- Flush: bubble loaded — every control output 0, `ResultSrcE`=000, `ALUControlE`=0000, `sizeE`=000, `RdE`/`Rs1E`/`Rs2E`=0, data fields 0. `FlushE` with `StallE` both high: flush wins.
- Halt FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when `doneD`=1 is captured by a normal load (not flushed, not stalled); counter loads `DRAIN_CYCLES`. The `done` bundle itself enters EX with `RegWriteE`=0 forced.
  - DRAIN: every non-stalled cycle loads bubbles regardless of `D` inputs; counter decrements; at counter==1 next state HALTED. `FlushE` in DRAIN is harmless (bubble anyway).
  - HALTED: `haltedE`=1, register holds bubble, ignores all inputs until reset.
- `doneD` while stalled or flushed: ignored (instruction not yet captured).

## Timing
- Latency: 1 cycle D->E.
- `haltedE` rises exactly `DRAIN_CYCLES`+1 edges after the edge capturing `done` (absent stalls); each stall cycle in DRAIN adds one cycle.
- Reset (async, any state incl. mid-DRAIN): all outputs 0, FSM RUN, counter 0, `bubble_cnt` 0; release takes effect at next edge.
- `BranchE` combinational from registered outputs; no extra latency.

## Configuration
- `IDEX_PERF_CNT_EN` defined: 32-bit `bubble_cnt` increments on every edge where a flush-induced bubble is loaded (FlushE=1, not halted, not reset); wraps 0xFFFFFFFF->0; DRAIN bubbles not counted.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `riscv_pipe_pkg`: `ResultSrc` encodings, `ALUControl` width, `sizeD` encodings, `DONE_OPCODE`, halt state enum, bubble constant values.
- One sub-module: `halt_drain_fsm` (state, drain counter, `load_bubble`/`hold`/`haltedE` outputs); the top holds the registers and load-priority muxing.

## Test plan
- Add x5,x6,x7 (RegWriteD=1, ALUControlD=0000, RdD=7, RD1D=5, RD2D=9) -> next edge RegWriteE=1, RdE=7, RD1E=5, RD2E=9.
- Load beq bundle, then StallE=1 for 2 cycles with new D values -> beqE=1, BranchE=1, PCE unchanged through both stall cycles.
- FlushE=1 and StallE=1 with sw bundle -> Mem_WriteE=0, RdE=0, all controls 0; with perf macro bubble_cnt 0->1.
- doneD=1 captured at edge N -> bubbles at N+1..N+3 despite live D inputs, haltedE=1 from edge N+4, remains 1 for 20 further cycles.
- Same as previous with StallE=1 one cycle during DRAIN -> haltedE at N+5.
- Async reset asserted mid-DRAIN between edges -> outputs 0 immediately, haltedE=0, FSM RUN; subsequent add instruction propagates normally.
